// File: rtl/gpout_router.sv
// -----------------------------------------------------------------------------
// gpout_router
//   Routes any of NUM_SRC internal probe signals to any of NUM_CH registered
//   general-purpose outputs. The per-channel select table is loaded over a
//   3-wire serial config port (sclk/mosi/csb). A write is accepted only when
//   the reset-lock pair disagrees and the LA inputs are valid.
//
//   Frame (MSB first): {ch[CH_W-1:0], sel[SEL_W-1:0]}
//   With GPOUT_ROUTER_INVERT_EN defined, the frame becomes
//   {inv, ch, sel} and each output is XORed with its channel's invert flag.
//
// Ports
//   i_clk         design clock
//   i_reset_n     asynchronous active-low reset
//   i_src         source signals (i_clk domain)
//   i_cfg_sclk    config serial clock (async, oversampled)
//   i_cfg_mosi    config serial data  (async)
//   i_cfg_csb     config chip select, active low (async)
//   i_lock_a/b    reset-lock pair; writes need lock_a != lock_b
//   i_la_invalid  high blocks writes
//   o_gpout       routed outputs, registered
//   o_sel         select table, channel c at [c*SEL_W +: SEL_W]
//   o_cfg_done    1-cycle pulse, frame committed
//   o_cfg_err     1-cycle pulse, frame rejected
// -----------------------------------------------------------------------------
module gpout_router #(
   parameter int unsigned NUM_CH      = 6,
   parameter int unsigned SEL_W       = 6,
   parameter int unsigned NUM_SRC     = 64,
   parameter int unsigned CH_W        = 3,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                      i_clk,
   input  logic                      i_reset_n,
   input  logic [NUM_SRC-1:0]        i_src,
   input  logic                      i_cfg_sclk,
   input  logic                      i_cfg_mosi,
   input  logic                      i_cfg_csb,
   input  logic                      i_lock_a,
   input  logic                      i_lock_b,
   input  logic                      i_la_invalid,
   output logic [NUM_CH-1:0]         o_gpout,
   output logic [NUM_CH*SEL_W-1:0]   o_sel,
   output logic                      o_cfg_done,
   output logic                      o_cfg_err
);

`ifdef GPOUT_ROUTER_INVERT_EN
   localparam int unsigned FRAME_W = CH_W + SEL_W + 1;
`else
   localparam int unsigned FRAME_W = CH_W + SEL_W;
`endif
   localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);
   localparam int unsigned SRC_PAD = 2 ** SEL_W;
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_W + 1);
   localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_W);

   // Synchroniser bit positions: 0 sclk, 1 mosi, 2 csb, 3 lock_a, 4 lock_b.
   // csb idles high so the FSM does not see a spurious frame start.
   localparam logic [4:0] SYNC_RST = 5'b0_0100;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_COMMIT
   } state_e;

   logic [4:0]          sync_q [SYNC_STAGES];
   logic [4:0]          sync_d [SYNC_STAGES];
   logic                sclk_prev_q, sclk_prev_d;
   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [FRAME_W-1:0]  shreg_q, shreg_d;
   logic [SEL_W-1:0]    sel_q [NUM_CH];
   logic [SEL_W-1:0]    sel_d [NUM_CH];
   logic [NUM_CH-1:0]   inv_q, inv_d;
   logic [NUM_CH-1:0]   gpout_q, gpout_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic                sclk_s, mosi_s, csb_s, lock_a_s, lock_b_s;
   logic                sclk_rise;
   logic [CH_W-1:0]     frame_ch;
   logic [SEL_W-1:0]    frame_sel;
   logic                frame_inv;
   logic                frame_ok;
   logic [SRC_PAD-1:0]  src_pad;

   // ---------------------------------------------------------------- sync
   always_comb begin
      sync_d[0] = {i_lock_b, i_lock_a, i_cfg_csb, i_cfg_mosi, i_cfg_sclk};
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
         sync_d[s] = sync_q[s-1];
      end
   end

   assign sclk_s   = sync_q[SYNC_STAGES-1][0];
   assign mosi_s   = sync_q[SYNC_STAGES-1][1];
   assign csb_s    = sync_q[SYNC_STAGES-1][2];
   assign lock_a_s = sync_q[SYNC_STAGES-1][3];
   assign lock_b_s = sync_q[SYNC_STAGES-1][4];

   assign sclk_prev_d = sclk_s;
   assign sclk_rise   = sclk_s & ~sclk_prev_q;

   // --------------------------------------------------------- frame decode
   assign frame_sel = shreg_q[SEL_W-1:0];
   assign frame_ch  = shreg_q[SEL_W +: CH_W];
`ifdef GPOUT_ROUTER_INVERT_EN
   assign frame_inv = shreg_q[FRAME_W-1];
`else
   assign frame_inv = 1'b0;
`endif

   // ----------------------------------------------------------------- FSM
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shreg_d  = shreg_q;
      sel_d    = sel_q;
      inv_d    = inv_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      frame_ok = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!csb_s) begin
               state_d = ST_SHIFT;
               cnt_d   = '0;
               shreg_d = '0;
            end
         end

         ST_SHIFT: begin
            // csb release wins over a coincident sclk rise
            if (csb_s) begin
               state_d = ST_COMMIT;
            end else if (sclk_rise) begin
               shreg_d = {shreg_q[FRAME_W-2:0], mosi_s};
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         ST_COMMIT: begin
            frame_ok = (cnt_q == CNT_FRAME)
                    && ({1'b0, frame_ch} < (CH_W+1)'(NUM_CH))
                    && (lock_a_s != lock_b_s)
                    && !i_la_invalid;
            done_d   = frame_ok;
            err_d    = !frame_ok;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
               if (frame_ok && (frame_ch == CH_W'(c))) begin
                  sel_d[c] = frame_sel;
                  inv_d[c] = frame_inv;
               end
            end
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------ datapath
   // Zero-padding the source vector to 2**SEL_W makes out-of-range selects
   // read 0 without a separate range compare.
   always_comb begin
      src_pad                = '0;
      src_pad[NUM_SRC-1:0]   = i_src;
      gpout_d                = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         gpout_d[c] = src_pad[sel_q[c]] ^ inv_q[c];
      end
   end

   // ------------------------------------------------------------ registers
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= SYNC_RST;
         end
         sclk_prev_q <= 1'b0;
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         shreg_q     <= '0;
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            sel_q[c] <= SEL_W'(c % NUM_SRC);
         end
         inv_q       <= '0;
         gpout_q     <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         sclk_prev_q <= sclk_prev_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         sel_q       <= sel_d;
         inv_q       <= inv_d;
         gpout_q     <= gpout_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      o_sel = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         o_sel[c*SEL_W +: SEL_W] = sel_q[c];
      end
   end

   assign o_gpout    = gpout_q;
   assign o_cfg_done = done_q;
   assign o_cfg_err  = err_q;

endmodule

// File: tb/tb_gpout_router.sv
// -----------------------------------------------------------------------------
// tb_gpout_router
//   Directed frames over the serial config port. A table/latency model of the
//   router is compared against every output on every falling clock edge;
//   literal expectations for key points are checked by the same process.
//   NUM_SRC is overridden to 40 so selects 40..63 exercise the out-of-range
//   zero.
// -----------------------------------------------------------------------------
module tb_gpout_router;

   localparam int NUM_CH  = 6;
   localparam int SEL_W   = 6;
   localparam int NUM_SRC = 40;
   localparam int CH_W    = 3;
   localparam int SYNC    = 2;
`ifdef GPOUT_ROUTER_INVERT_EN
   localparam int FRAME_W = CH_W + SEL_W + 1;
`else
   localparam int FRAME_W = CH_W + SEL_W;
`endif
   // csb rise (driven at a falling edge) -> table/pulse change at the 4th
   // following rising edge: SYNC stages, one SHIFT->COMMIT step, one commit.
   localparam int COMMIT_LAT = SYNC + 2;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic [NUM_SRC-1:0]       src;
   logic                     sclk, mosi, csb, la, lb, lainv;
   logic [NUM_CH-1:0]        gpout;
   logic [NUM_CH*SEL_W-1:0]  osel;
   logic                     done, err;

   gpout_router #(
      .NUM_CH      (NUM_CH),
      .SEL_W       (SEL_W),
      .NUM_SRC     (NUM_SRC),
      .CH_W        (CH_W),
      .SYNC_STAGES (SYNC)
   ) dut (
      .i_clk        (clk),
      .i_reset_n    (rst_n),
      .i_src        (src),
      .i_cfg_sclk   (sclk),
      .i_cfg_mosi   (mosi),
      .i_cfg_csb    (csb),
      .i_lock_a     (la),
      .i_lock_b     (lb),
      .i_la_invalid (lainv),
      .o_gpout      (gpout),
      .o_sel        (osel),
      .o_cfg_done   (done),
      .o_cfg_err    (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ------------------------------------------------------------ model
   int                 m_sel [NUM_CH];
   logic [NUM_CH-1:0]  m_inv, m_gp;
   logic               m_done, m_err;

   int   ev_at = -1;
   int   ev_ch, ev_val;
   logic ev_ok, ev_inv;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CH; c++) m_sel[c] <= c % NUM_SRC;
         m_inv  <= '0;
         m_gp   <= '0;
         m_done <= 1'b0;
         m_err  <= 1'b0;
      end else begin
         for (int c = 0; c < NUM_CH; c++)
            m_gp[c] <= ((m_sel[c] < NUM_SRC) ? src[m_sel[c]] : 1'b0) ^ m_inv[c];
         if (cyc + 1 == ev_at) begin
            if (ev_ok) begin
               m_sel[ev_ch] <= ev_val;
               m_inv[ev_ch] <= ev_inv;
            end
            m_done <= ev_ok;
            m_err  <= !ev_ok;
         end else begin
            m_done <= 1'b0;
            m_err  <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------- checking
   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   int          pin_seq  = 0;
   int          pin_seen = 0;
   int          pin_what;
   logic [63:0] pin_mask, pin_exp;
   string       pin_name;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic [NUM_CH*SEL_W-1:0] es;
      logic [63:0]             act;
      if (chk_en) begin
         es = '0;
         for (int c = 0; c < NUM_CH; c++) es[c*SEL_W +: SEL_W] = SEL_W'(m_sel[c]);
         check("gpout", 64'(gpout), 64'(m_gp));
         check("sel",   64'(osel),  64'(es));
         check("done",  64'(done),  64'(m_done));
         check("err",   64'(err),   64'(m_err));
         if (pin_seq != pin_seen) begin
            pin_seen = pin_seq;
            act = (pin_what == 0) ? 64'(gpout) : 64'(osel);
            check(pin_name, act & pin_mask, pin_exp);
         end
      end
   end

   // Literal expectation: what 0 = o_gpout, 1 = o_sel.
   task automatic pin(input int what, input logic [63:0] mask,
                      input logic [63:0] exp, input string name);
      pin_what = what;
      pin_mask = mask;
      pin_exp  = exp;
      pin_name = name;
      pin_seq++;
      repeat (2) @(negedge clk);
   endtask

   function automatic logic [15:0] mk(input int inv, input int ch, input int sel);
      return 16'((inv << (CH_W + SEL_W)) | (ch << SEL_W) | sel);
   endfunction

   task automatic send_bit(input logic b);
      mosi = b;
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] bits, input int n);
      int   ch, val;
      logic inv;
      @(negedge clk);
      csb = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
      repeat (4) @(negedge clk);
      ch  = int'(bits[SEL_W +: CH_W]);
      val = int'(bits[SEL_W-1:0]);
`ifdef GPOUT_ROUTER_INVERT_EN
      inv = bits[FRAME_W-1];
`else
      inv = 1'b0;
`endif
      ev_ch  = ch;
      ev_val = val;
      ev_inv = inv;
      ev_ok  = (n == FRAME_W) && (ch < NUM_CH) && (la != lb) && !lainv;
      ev_at  = cyc + COMMIT_LAT;
      csb    = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   localparam logic [63:0] SEL_MASK = 64'hF_FFFF_FFFF;
   localparam logic [63:0] GP_MASK  = 64'h3F;

   initial begin
      logic [15:0] fr;
      rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; csb = 1'b1;
      la = 1'b0; lb = 1'b0; lainv = 1'b0; src = '0;
      repeat (4) @(negedge clk);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);
      pin(1, SEL_MASK, 64'h1440C2040, "reset_sel_table");
      pin(0, GP_MASK, 64'h0, "reset_gpout");

      src = 40'h4;
      repeat (2) @(negedge clk);
      pin(0, GP_MASK, 64'b000100, "default_ch2_route");

      // valid write: ch2 <- 17
      la = 1'b1; lb = 1'b0; src = 40'h2_0000;
      repeat (5) @(negedge clk);
      send_frame(mk(0, 2, 17), FRAME_W);
      pin(1, 64'h3F << 12, 64'(17) << 12, "ch2_sel17");
      pin(0, GP_MASK, 64'b000100, "ch2_routes_src17");

      // lock pair equal, then LA invalid: both rejected
      lb = 1'b1;
      repeat (5) @(negedge clk);
      send_frame(mk(0, 2, 9), FRAME_W);
      lb = 1'b0; lainv = 1'b1;
      repeat (5) @(negedge clk);
      send_frame(mk(0, 2, 9), FRAME_W);
      lainv = 1'b0;
      pin(1, 64'h3F << 12, 64'(17) << 12, "ch2_unchanged_after_rejects");

      // short, long, bad-channel and empty frames: all rejected
      send_frame(mk(0, 3, 9), FRAME_W - 1);
      send_frame(mk(0, 3, 9), FRAME_W + 1);
      send_frame(mk(0, 7, 9), FRAME_W);
      send_frame(16'h0, 0);
      pin(1, SEL_MASK, 64'h1440D1040, "table_after_bad_frames");

      // select boundaries around NUM_SRC
      src = '1;
      send_frame(mk(0, 0, 63), FRAME_W);
      send_frame(mk(0, 1, 39), FRAME_W);
      send_frame(mk(0, 5, 40), FRAME_W);
      pin(0, GP_MASK, 64'b011110, "out_of_range_selects");

      // reset in the middle of a frame
      fr = mk(0, 4, 33);
      @(negedge clk);
      csb = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = FRAME_W - 1; i >= FRAME_W - 4; i--) send_bit(fr[i]);
      #2;
      rst_n = 1'b0; csb = 1'b1; sclk = 1'b0;
      @(negedge clk);
      pin(0, GP_MASK, 64'h0, "midframe_reset_gpout");
      pin(1, SEL_MASK, 64'h1440C2040, "midframe_reset_table");
      rst_n = 1'b1;
      src = 40'h2_0000_0000;
      repeat (3) @(negedge clk);
      send_frame(mk(0, 4, 33), FRAME_W);
      pin(1, 64'h3F << 24, 64'(33) << 24, "post_reset_ch4_sel33");
      pin(0, GP_MASK, 64'b010000, "post_reset_ch4_route");

`ifdef GPOUT_ROUTER_INVERT_EN
      src = '0;
      send_frame(mk(1, 1, 5), FRAME_W);
      pin(0, 64'b000010, 64'b000010, "invert_ch1");
`endif

      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
